// File: rtl/rf_write_arbiter4.sv
// Round-robin arbiter for the single register-file write port; combinational grant, registered write one cycle later.
// stall or reset forces grant=0000; writes to the all-ones (zero) register are granted but leave wr_en low.
module rf_write_arbiter4 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  input  logic                    stall,
  output logic [3:0]              grant,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [1:0]              wr_src
);

  logic [1:0]            ptr;
  logic [1:0]            gidx;
  logic                  gvld;
  logic [1:0]            idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan from ptr upward (mod 4); first requester found wins.
  always_comb begin
    gvld = 1'b0;
    gidx = 2'd0;
    idx  = 2'd0;
    if (!reset && !stall) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!gvld && req[idx]) begin
          gvld = 1'b1;
          gidx = idx;
        end
      end
    end
    grant = gvld ? (4'b0001 << gidx) : 4'b0000;
  end

  assign sel_addr = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 2'd0;
    end else if (gvld) begin
      ptr     <= gidx + 2'd1;
      wr_en   <= ~&sel_addr;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_src  <= gidx;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter4.sv
// Directed bench for rf_write_arbiter4: inputs change on the falling edge, grant is checked
// mid-cycle and the registered write port just after the following rising edge.
module tb_rf_write_arbiter4;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_data;
  logic          stall;
  logic [3:0]    grant;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_src;

  int errors = 0;
  int checks = 0;

  rf_write_arbiter4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .stall(stall), .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = DW'(64'h100 + i);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (wr_src !== 2'd0) begin errors++; $display("FAIL reset_wr_src got=%0d exp=0", wr_src); end
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0001;
    req_addr[0 +: AW] = 5'd5;
    req_data[0 +: DW] = 64'hAA;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", grant); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
    checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL single_wr_addr got=%0d exp=5", wr_addr); end
    checks++; if (wr_data !== 64'hAA) begin errors++; $display("FAIL single_wr_data got=%h exp=aa", wr_data); end
    checks++; if (wr_src !== 2'd0) begin errors++; $display("FAIL single_wr_src got=%0d exp=0", wr_src); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got=%b exp=0000", grant); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL idle_wr_addr_hold got=%0d exp=5", wr_addr); end
  endtask

  // ptr is 1 here from the single write: 0011 must go to 1 first, then wrap to 0.
  task automatic test_wrap();
    @(negedge clk);
    req = 4'b0011;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_grant0 got=%b exp=0010", grant); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant1 got=%b exp=0001", grant); end
    checks++; if (wr_src !== 2'd1) begin errors++; $display("FAIL wrap_wr_src got=%0d exp=1", wr_src); end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = DW'(64'h10 + i);
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      eg = 4'b0001 << (c % 4);
      #1;
      checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, eg); end
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b1 || wr_src !== 2'(c % 4) || wr_addr !== AW'(c % 4 + 1) || wr_data !== DW'(64'h10 + c % 4)) begin
        errors++;
        $display("FAIL rr_write c=%0d got en=%b src=%0d addr=%0d data=%h exp en=1 src=%0d addr=%0d",
                 c, wr_en, wr_src, wr_addr, wr_data, c % 4, c % 4 + 1);
      end
      @(negedge clk);
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req = 4'b0100;
    req_addr[2*AW +: AW] = 5'd7;
    req_data[2*DW +: DW] = 64'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL b2b_grant c=%0d got=%b exp=0100", c, grant); end
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b1 || wr_src !== 2'd2 || wr_addr !== 5'd7) begin
        errors++; $display("FAIL b2b_write c=%0d got en=%b src=%0d addr=%0d exp en=1 src=2 addr=7", c, wr_en, wr_src, wr_addr);
      end
      @(negedge clk);
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_reg();
    do_reset();
    req = 4'b0001;
    req_addr[0 +: AW] = 5'd31;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL x31_grant got=%b exp=0001", grant); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x31_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 5'd31) begin errors++; $display("FAIL x31_wr_addr got=%0d exp=31", wr_addr); end
    @(negedge clk);
    req = 4'b0011;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL x31_ptr_advanced got=%b exp=0010", grant); end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_stall_reset();
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = AW'(i + 1);
    req   = 4'b1111;
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_grant c=%0d got=%b exp=0000", c, grant); end
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en c=%0d got=%b exp=0", c, wr_en); end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL post_stall_grant got=%b exp=0001", grant); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL post_stall_grant1 got=%b exp=0010", grant); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pre_reset_grant got=%b exp=0100", grant); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL pre_reset_wr_en got=%b exp=1", wr_en); end
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midreset_grant got=%b exp=0000", grant); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en got=%b exp=0", wr_en); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_edge_wr_en got=%b exp=0", wr_en); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL after_reset_grant got=%b exp=0001", grant); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1 || wr_src !== 2'd0 || wr_addr !== 5'd1) begin
      errors++; $display("FAIL after_reset_write got en=%b src=%0d addr=%0d exp en=1 src=0 addr=1", wr_en, wr_src, wr_addr);
    end
    @(negedge clk);
    req = 4'b0000;
  endtask

  initial begin
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_back_to_back();
    test_zero_reg();
    test_stall_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
